// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-side and result channels of the ALU op sequencer.
// The master side is the instruction source plus the ALU; the slave side is the sequencer.
interface alu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [4:0]  in_operad;
    logic [3:0]  in_rd_reg1;
    logic [3:0]  in_rd_reg2;
    logic [2:0]  alu_opcode;
    logic [4:0]  alu_operad;
    logic [3:0]  alu_rd_reg1;
    logic [3:0]  alu_rd_reg2;
    logic        alu_start;
    logic [3:0]  alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_result;
    logic [2:0]  out_opcode;
    logic        busy;
    logic [15:0] op_count;

    modport master (
        output in_valid, in_opcode, in_operad, in_rd_reg1, in_rd_reg2,
        output alu_result, out_ready,
        input  in_ready, alu_opcode, alu_operad, alu_rd_reg1, alu_rd_reg2, alu_start,
        input  out_valid, out_result, out_opcode, busy, op_count
    );

    modport slave (
        input  in_valid, in_opcode, in_operad, in_rd_reg1, in_rd_reg2,
        input  alu_result, out_ready,
        output in_ready, alu_opcode, alu_operad, alu_rd_reg1, alu_rd_reg2, alu_start,
        output out_valid, out_result, out_opcode, busy, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU instructions, issues each with a one-cycle start strobe, waits ALU_LAT
// cycles and returns the captured result. Define ALU_SEQ_STATS_EN to enable op_count.
module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      fifo_mem_r [DEPTH];
    logic [15:0]      head_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [LAT_W-1:0] wait_cnt_r;
    logic             push_s;
    logic             pop_s;
    logic             capture_s;
    logic             handshake_s;
    logic             in_ready_r;
    logic             busy_r;
    logic             alu_start_r;
    logic             out_valid_r;
    logic [2:0]       alu_opcode_r;
    logic [4:0]       alu_operad_r;
    logic [3:0]       alu_rd_reg1_r;
    logic [3:0]       alu_rd_reg2_r;
    logic [3:0]       out_result_r;
    logic [2:0]       out_opcode_r;

    // in_ready is registered, so a slot freed by a pop is only offered one cycle later
    assign push_s = bus.in_valid && in_ready_r;
    assign head_s = fifo_mem_r[rd_ptr_r];

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_r == LAT_ZERO) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    handshake_s = 1'b1;
                    if (count_r != CNT_ZERO) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1'b1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {bus.in_opcode, bus.in_operad, bus.in_rd_reg1, bus.in_rd_reg2};
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered status flags, computed from next-cycle state so they track it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            in_ready_r <= (count_nxt_s != CNT_FULL);
            busy_r     <= (state_nxt_s != ST_IDLE) || (count_nxt_s != CNT_ZERO);
        end
    end

    // ALU operand registers and issue strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_opcode_r  <= 3'd0;
            alu_operad_r  <= 5'd0;
            alu_rd_reg1_r <= 4'd0;
            alu_rd_reg2_r <= 4'd0;
            alu_start_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                alu_opcode_r  <= head_s[15:13];
                alu_operad_r  <= head_s[12:8];
                alu_rd_reg1_r <= head_s[7:4];
                alu_rd_reg2_r <= head_s[3:0];
            end
            alu_start_r <= (state_nxt_s == ST_ISSUE);
        end
    end

    // ALU latency countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= LAT_ZERO;
        end else if (state_r == ST_ISSUE) begin
            wait_cnt_r <= LAT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != LAT_ZERO)) begin
            wait_cnt_r <= wait_cnt_r - LAT_W'(1'b1);
        end
    end

    // Result capture and output-channel valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_result_r <= 4'd0;
            out_opcode_r <= 3'd0;
            out_valid_r  <= 1'b0;
        end else if (capture_s) begin
            out_result_r <= bus.alu_result;
            out_opcode_r <= alu_opcode_r;
            out_valid_r  <= 1'b1;
        end else if (handshake_s) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count_r;

    // Saturating count of completed result handshakes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_r <= 16'h0000;
        end else if (handshake_s && (op_count_r != 16'hFFFF)) begin
            op_count_r <= op_count_r + 16'h0001;
        end
    end

    assign bus.op_count = op_count_r;
`else
    assign bus.op_count = 16'h0000;
`endif

    assign bus.in_ready    = in_ready_r;
    assign bus.busy        = busy_r;
    assign bus.alu_opcode  = alu_opcode_r;
    assign bus.alu_operad  = alu_operad_r;
    assign bus.alu_rd_reg1 = alu_rd_reg1_r;
    assign bus.alu_rd_reg2 = alu_rd_reg2_r;
    assign bus.alu_start   = alu_start_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_opcode  = out_opcode_r;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer (DEPTH=4, ALU_LAT=2); the ALU is modelled as
// result = rd_reg1 + rd_reg2 + opcode (mod 16). op_count expectations follow ALU_SEQ_STATS_EN.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
`ifdef ALU_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.DEPTH(4), .ALU_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.alu_result = bus.alu_rd_reg1 + bus.alu_rd_reg2 + {1'b0, bus.alu_opcode};

    int         cyc = 0;
    int         start_cnt = 0;
    int         start_cyc [$];
    logic [6:0] got [$];

    // Observe strobes and completed handshakes mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (rst && bus.alu_start) begin
            start_cnt++;
            start_cyc.push_back(cyc);
        end
        if (rst && bus.out_valid && bus.out_ready) begin
            got.push_back({bus.out_opcode, bus.out_result});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] opc, input logic [4:0] opd,
                         input logic [3:0] r1, input logic [3:0] r2);
        bus.in_valid   = 1'b1;
        bus.in_opcode  = opc;
        bus.in_operad  = opd;
        bus.in_rd_reg1 = r1;
        bus.in_rd_reg2 = r2;
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [2:0] f_opc [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [3:0] f_r1  [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11};
    logic [3:0] f_r2  [6] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12};
    logic [3:0] f_exp [5] = '{4'd4, 4'd9, 4'd14, 4'd3, 4'd8};
    logic [6:0] s_exp [3] = '{{3'd7, 4'd9}, {3'd2, 4'd0}, {3'd3, 4'd8}};

    initial begin
        int n;
        int acc;
        int sc;
        logic busy_at2;
        logic ov_seen;

        // Reset held with an instruction offered
        bus.in_valid   = 1'b1;
        bus.in_opcode  = 3'd5;
        bus.in_operad  = 5'd7;
        bus.in_rd_reg1 = 4'd3;
        bus.in_rd_reg2 = 4'd3;
        bus.out_ready  = 1'b0;
        repeat (10) tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_alu_start", bus.alu_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_alu_fields", {bus.alu_opcode, bus.alu_operad, bus.alu_rd_reg1, bus.alu_rd_reg2}, 0);
        check("rst_out_fields", {bus.out_opcode, bus.out_result}, 0);
        check("rst_op_count", bus.op_count, 0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_busy", bus.busy, 0);
        repeat (3) tick();
        check("rel_no_push_busy", bus.busy, 0);
        check("rel_no_start", start_cnt, 0);

        // Single operation, out_ready high
        bus.out_ready = 1'b1;
        offer(3'd0, 5'd1, 4'd5, 4'd4);
        check("single_busy_after_push", bus.busy, 1);
        tick();
        check("single_start", bus.alu_start, 1);
        check("single_rd1", bus.alu_rd_reg1, 5);
        check("single_rd2", bus.alu_rd_reg2, 4);
        check("single_operad", bus.alu_operad, 1);
        tick();
        check("single_start_low", bus.alu_start, 0);
        tick();
        check("single_valid_early", bus.out_valid, 0);
        tick();
        check("single_valid", bus.out_valid, 1);
        check("single_result", bus.out_result, 9);
        check("single_opcode", bus.out_opcode, 0);
        tick();
        check("single_valid_clr", bus.out_valid, 0);
        check("single_busy_clr", bus.busy, 0);
        check("single_start_cnt", start_cnt, 1);
        check("single_op_count", bus.op_count, STATS ? 1 : 0);

        // Fill the FIFO with out_ready low
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_opcode  = f_opc[i];
            bus.in_operad  = 5'(i + 2);
            bus.in_rd_reg1 = f_r1[i];
            bus.in_rd_reg2 = f_r2[i];
            if (i == 5) check("full_in_ready_6th", bus.in_ready, 0);
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("full_accepted", acc, 5);
        got.delete();
        bus.out_ready = 1'b1;
        n = 0;
        while (got.size() < 5 && n < 80) begin
            tick();
            n++;
        end
        check("full_drain_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_order_%0d", i), (i < got.size()) ? got[i] : 7'h7f, {f_opc[i], f_exp[i]});
        end
        repeat (10) tick();
        check("full_no_extra", got.size(), 5);
        check("full_busy_clr", bus.busy, 0);
        check("full_in_ready", bus.in_ready, 1);

        // Back-pressure on a pending result
        bus.out_ready = 1'b0;
        got.delete();
        offer(3'd0, 5'd1, 4'd5, 4'd4);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_rise", bus.out_valid, 1);
        sc = start_cnt;
        repeat (10) begin
            tick();
            check("bp_valid_hold", bus.out_valid, 1);
            check("bp_result_hold", bus.out_result, 9);
        end
        check("bp_no_start", start_cnt, sc);
        bus.out_ready = 1'b1;
        tick();
        check("bp_valid_clr", bus.out_valid, 0);
        check("bp_one_result", got.size(), 1);

        // Streaming three ops with out_ready held high
        got.delete();
        start_cyc.delete();
        bus.in_valid   = 1'b1;
        bus.in_opcode  = 3'd7; bus.in_operad = 5'd0; bus.in_rd_reg1 = 4'd1;  bus.in_rd_reg2 = 4'd1;
        tick();
        bus.in_opcode  = 3'd2; bus.in_rd_reg1 = 4'd15; bus.in_rd_reg2 = 4'd15;
        tick();
        bus.in_opcode  = 3'd3; bus.in_rd_reg1 = 4'd2;  bus.in_rd_reg2 = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        busy_at2 = 1'b0;
        n = 0;
        while (got.size() < 3 && n < 60) begin
            tick();
            n++;
            if (got.size() == 2 && bus.busy) busy_at2 = 1'b1;
        end
        check("stream_count", got.size(), 3);
        check("stream_busy_mid", busy_at2, 1);
        check("stream_busy_fall", bus.busy, 0);
        check("stream_starts", start_cyc.size(), 3);
        check("stream_gap1", (start_cyc.size() == 3) ? start_cyc[1] - start_cyc[0] : 0, 4);
        check("stream_gap2", (start_cyc.size() == 3) ? start_cyc[2] - start_cyc[1] : 0, 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream_res_%0d", i), (i < got.size()) ? got[i] : 7'h7f, s_exp[i]);
        end

        // Reset during WAIT after two completed ops
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        got.delete();
        offer(3'd1, 5'd0, 4'd1, 4'd1);
        offer(3'd2, 5'd0, 4'd2, 4'd1);
        n = 0;
        while (got.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        check("mid_two_done", got.size(), 2);
        check("mid_op_count_before", bus.op_count, STATS ? 2 : 0);
        offer(3'd0, 5'd0, 4'd2, 4'd2);
        tick();
        tick();
        check("mid_in_wait_valid", bus.out_valid, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_op_count", bus.op_count, 0);
        repeat (3) tick();
        rst = 1'b1;
        got.delete();
        ov_seen = 1'b0;
        sc = start_cnt;
        repeat (8) begin
            tick();
            if (bus.out_valid) ov_seen = 1'b1;
        end
        check("mid_no_valid", ov_seen, 0);
        check("mid_no_start", start_cnt, sc);
        check("mid_fifo_empty", bus.busy, 0);
        check("mid_in_ready", bus.in_ready, 1);
        check("mid_op_count_after", bus.op_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the ALU datapath: queues ALU instructions {opcode, operad, rd_reg1, rd_reg2} from a requester through a valid/ready FIFO.
- Issues each instruction to the ALU with a one-cycle start strobe, waits a fixed ALU latency, then captures the ALU result.
- Returns the result to the requester over a valid/ready output channel.
- Sits between the instruction source (bench or future decoder) and the ALU; the ALU itself is unchanged.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of 2, minimum 2.
- ALU_LAT, 2, cycles from alu_start to valid alu_result; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  FIFO can accept an instruction.
- in_opcode  input  3  ALU opcode.
- in_operad  input  5  operand / destination control field.
- in_rd_reg1  input  4  register-file read address 1.
- in_rd_reg2  input  4  register-file read address 2.
- alu_opcode  output  3  registered opcode to ALU.
- alu_operad  output  5  registered operad to ALU.
- alu_rd_reg1  output  4  registered read address 1.
- alu_rd_reg2  output  4  registered read address 2.
- alu_start  output  1  one-cycle issue strobe.
- alu_result  input  4  ALU result.
- out_valid  output  1  result available.
- out_ready  input  1  requester accepts result.
- out_result  output  4  captured ALU result.
- out_opcode  output  3  opcode of the returned result.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- op_count  output  16  completed-operation counter (see Optional Feature).

Behaviour:
- Reset (rst low, async):
  - FIFO emptied; FSM to IDLE.
  - All outputs 0, including in_ready; any in-flight operation is discarded.
  - After release, in_ready = 1.
- FIFO:
  - Push on in_valid && in_ready.
  - in_ready = (count != DEPTH), derived from the registered count only, so a pop does not free a slot in the same cycle.
  - Pointers wrap modulo DEPTH. Order is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If FIFO non-empty: pop the head, latch its fields into the alu_* registers, go to ISSUE.
  - Otherwise stay.
- ISSUE:
  - alu_start = 1 for exactly this cycle.
  - Load wait counter with ALU_LAT-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture alu_result into out_result and alu_opcode into out_opcode, set out_valid, go to DONE.
- DONE:
  - out_valid held high; out_result and out_opcode held stable until out_ready.
  - On out_valid && out_ready with FIFO non-empty: pop and go directly to ISSUE.
  - On out_valid && out_ready with FIFO empty: go to IDLE.
  - out_valid clears on the handshake edge.
- alu_* fields hold their last issued value outside ISSUE; alu_start is 0 in every state except ISSUE.
- Latency: for an instruction pushed at edge E into an idle, empty block, out_valid rises after edge E+ALU_LAT+2.
- Back-to-back issue spacing with out_ready held high: ALU_LAT+2 cycles.
- Simultaneous push and pop are allowed when not full; count is unchanged.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined: op_count increments by 1 on each out_valid && out_ready handshake, saturates at 16'hFFFF, and clears on reset.
- Not defined: op_count is tied to 0 and no counter logic is synthesised; the port remains present.

Test Plan:
- Reset: hold rst low 10 cycles with in_valid=1 -> all outputs 0, in_ready 0; after release in_ready=1, busy=0, no push occurred during reset.
- Single op: push opcode=0, operad=1, rd_reg1=5, rd_reg2=4 with ALU model returning 9; ALU_LAT=2, out_ready=1 -> alu_start high exactly 1 cycle with alu_rd_reg1=5, alu_rd_reg2=4; out_valid after push edge +4; out_result=9, out_opcode=0.
- Full: DEPTH=4, out_ready=0, push 6 distinct ops back-to-back -> ops 1–5 accepted; in_ready=0 when the 6th is offered. Then raise out_ready -> results return in push order with no loss or duplication.
- Back-pressure: result 9 pending, out_ready low 10 cycles -> out_result stays 9, out_valid stays 1, no alu_start pulses.
- Streaming: 3 ops queued, out_ready tied 1, ALU_LAT=2 -> alu_start pulses exactly 4 cycles apart; busy falls one cycle after the third handshake.
- Reset mid-WAIT (with ALU_SEQ_STATS_EN, 2 ops already completed): assert rst during WAIT -> out_valid never rises for that op, FIFO empty, op_count returns to 0 (was 2).
